alu_driver: RTL and testbench

Command-side controller for the 8-bit ALU core: accepts one operation request (left operand, right operand, opcode) over a valid/ready handshake and drives the ALU's three strobe-loaded input registers (`numLeft`/`clkNumLeft`, `numRight`/`clkNumRight`, `opChoose`/`clkOpChoose`) with correct setup, pulse width and settle timing. It then samples the ALU `result` and returns it over a valid/ready response handshake. It sits between any system master (CPU bus bridge, test sequencer) and the ALU core, and replaces hand-timed strobe generation.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_strobe_timer.sv | 28 ++
 rtl/alu_driver.sv | 129 ++++++++++++
 tb/tb_alu_driver.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command-side driver.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 8;

  typedef logic [ALU_WIDTH-1:0] alu_op_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    SETTLE,
    RESP
  } alu_driver_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_strobe_timer.sv
// Loadable down-counter; done_c is high while the count sits at zero.
module alu_strobe_timer
  import alu_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done_c
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done_c = (count == '0);

endmodule

// File: rtl/alu_driver.sv
// Valid/ready front end that sequences the ALU load strobes and returns its result.
// Optional ALU_DRIVER_SKIP_UNCHANGED_EN: only strobe operands that differ from the last load.
module alu_driver
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH    = ALU_WIDTH,
  parameter int unsigned STROBE_W = 1,
  parameter int unsigned SETTLE   = 2
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             cmdValid,
  output logic             cmdReady,
  input  logic [WIDTH-1:0] cmdLeft,
  input  logic [WIDTH-1:0] cmdRight,
  input  logic [WIDTH-1:0] cmdOp,
  output logic             rspValid,
  input  logic             rspReady,
  output logic [WIDTH-1:0] rspResult,
  output logic [WIDTH-1:0] numLeft,
  output logic [WIDTH-1:0] numRight,
  output logic [WIDTH-1:0] opChoose,
  output logic             clkNumLeft,
  output logic             clkNumRight,
  output logic             clkOpChoose,
  input  logic [WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(max_u(STROBE_W, SETTLE)) + 1;

  alu_driver_state_t state, next_state;
  logic              accept;
  logic              tmr_load;
  logic              tmr_done;
  logic [CNT_W-1:0]  tmr_val;
  logic [2:0]        strobe_en;

  assign accept = (state == IDLE) && cmdValid;

  alu_strobe_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rstN),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done_c   (tmr_done)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= next_state;
  end

  // SETTLE is loaded with SETTLE (SETTLE+1 cycles) because the visible strobe trails the state by one cycle.
  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    unique case (state)
      IDLE: begin
        if (cmdValid) next_state = SETUP;
      end
      SETUP: begin
        next_state = STROBE;
        tmr_load   = 1'b1;
        tmr_val    = CNT_W'(STROBE_W - 1);
      end
      STROBE: begin
        if (tmr_done) begin
          next_state = alu_pkg::SETTLE;
          tmr_load   = 1'b1;
          tmr_val    = CNT_W'(SETTLE);
        end
      end
      alu_pkg::SETTLE: begin
        if (tmr_done) next_state = RESP;
      end
      RESP: begin
        if (rspReady) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef ALU_DRIVER_SKIP_UNCHANGED_EN
  logic loaded;

  // The data outputs double as the memory of the last values loaded into the ALU.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      loaded    <= 1'b0;
      strobe_en <= 3'b111;
    end else if (accept) begin
      loaded    <= 1'b1;
      strobe_en <= {!loaded || (cmdOp    != opChoose),
                    !loaded || (cmdRight != numRight),
                    !loaded || (cmdLeft  != numLeft)};
    end
  end
`else
  assign strobe_en = 3'b111;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cmdReady    <= 1'b1;
      rspValid    <= 1'b0;
      rspResult   <= '0;
      numLeft     <= '0;
      numRight    <= '0;
      opChoose    <= '0;
      clkNumLeft  <= 1'b0;
      clkNumRight <= 1'b0;
      clkOpChoose <= 1'b0;
    end else begin
      cmdReady    <= (next_state == IDLE);
      rspValid    <= (next_state == RESP);
      clkNumLeft  <= (state == STROBE) && strobe_en[0];
      clkNumRight <= (state == STROBE) && strobe_en[1];
      clkOpChoose <= (state == STROBE) && strobe_en[2];
      if (accept) begin
        numLeft  <= cmdLeft;
        numRight <= cmdRight;
        opChoose <= cmdOp;
      end
      if ((state == alu_pkg::SETTLE) && tmr_done) rspResult <= result;
    end
  end

endmodule

// File: tb/tb_alu_driver.sv
// Bench for alu_driver: two instances (default timing and STROBE_W=3/SETTLE=4) driving a behavioural ALU.
module tb_alu_driver;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       cmd_valid [N];
  logic       cmd_ready [N];
  logic [7:0] cmd_left  [N];
  logic [7:0] cmd_right [N];
  logic [7:0] cmd_op    [N];
  logic       rsp_valid [N];
  logic       rsp_ready [N];
  logic [7:0] rsp_result[N];
  logic [7:0] num_l     [N];
  logic [7:0] num_r     [N];
  logic [7:0] op_c      [N];
  logic       clk_l     [N];
  logic       clk_r     [N];
  logic       clk_o     [N];
  logic [7:0] result    [N];

  int checks = 0;
  int failures = 0;

  bit         mvalid [N];
  logic [7:0] last_l [N];
  logic [7:0] last_r [N];
  logic [7:0] last_o [N];

  function automatic int sw_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int st_of(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  // Behavioural ALU: opcode low bits select sub/add/and/xor.
  function automatic logic [7:0] ref_fn(input logic [7:0] l, input logic [7:0] r, input logic [7:0] o);
    int a, b;
    a = int'(l);
    b = int'(r);
    case (int'(o) % 4)
      0:       return 8'((a - b + 256) % 256);
      1:       return 8'((a + b) % 256);
      2:       return l & r;
      default: return l ^ r;
    endcase
  endfunction

  alu_driver #(.WIDTH(8), .STROBE_W(1), .SETTLE(2)) dut0 (
    .clk(clk), .rstN(rst_n),
    .cmdValid(cmd_valid[0]), .cmdReady(cmd_ready[0]),
    .cmdLeft(cmd_left[0]), .cmdRight(cmd_right[0]), .cmdOp(cmd_op[0]),
    .rspValid(rsp_valid[0]), .rspReady(rsp_ready[0]), .rspResult(rsp_result[0]),
    .numLeft(num_l[0]), .numRight(num_r[0]), .opChoose(op_c[0]),
    .clkNumLeft(clk_l[0]), .clkNumRight(clk_r[0]), .clkOpChoose(clk_o[0]),
    .result(result[0])
  );

  alu_driver #(.WIDTH(8), .STROBE_W(3), .SETTLE(4)) dut1 (
    .clk(clk), .rstN(rst_n),
    .cmdValid(cmd_valid[1]), .cmdReady(cmd_ready[1]),
    .cmdLeft(cmd_left[1]), .cmdRight(cmd_right[1]), .cmdOp(cmd_op[1]),
    .rspValid(rsp_valid[1]), .rspReady(rsp_ready[1]), .rspResult(rsp_result[1]),
    .numLeft(num_l[1]), .numRight(num_r[1]), .opChoose(op_c[1]),
    .clkNumLeft(clk_l[1]), .clkNumRight(clk_r[1]), .clkOpChoose(clk_o[1]),
    .result(result[1])
  );

  // Strobe-loaded ALU input registers, one set per instance.
  for (genvar g = 0; g < N; g++) begin : g_alu
    logic [7:0] a_l = 8'h00;
    logic [7:0] a_r = 8'h00;
    logic [7:0] a_o = 8'h00;
    always @(posedge clk_l[g]) a_l <= num_l[g];
    always @(posedge clk_r[g]) a_r <= num_r[g];
    always @(posedge clk_o[g]) a_o <= op_c[g];
    assign result[g] = ref_fn(a_l, a_r, a_o);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance i; bp>0 holds rspReady low for bp cycles with a stray cmdValid.
  task automatic run_op(input int i, input logic [7:0] l, input logic [7:0] r, input logic [7:0] o,
                        input int bp, input bit ready_early);
    int lat, nl, nr, no, waitc;
    bit busy_bad, data_bad, stable;
    bit el, er, eo;
    logic [7:0] hold;
`ifdef ALU_DRIVER_SKIP_UNCHANGED_EN
    el = !mvalid[i] || (l != last_l[i]);
    er = !mvalid[i] || (r != last_r[i]);
    eo = !mvalid[i] || (o != last_o[i]);
`else
    el = 1'b1; er = 1'b1; eo = 1'b1;
`endif
    mvalid[i] = 1'b1; last_l[i] = l; last_r[i] = r; last_o[i] = o;

    @(negedge clk);
    waitc = 0;
    while (!cmd_ready[i] && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check("ready_wait", 32'(waitc), 32'd0);
    cmd_valid[i] = 1'b1; cmd_left[i] = l; cmd_right[i] = r; cmd_op[i] = o;
    rsp_ready[i] = ready_early;
    @(negedge clk);
    cmd_valid[i] = 1'b0;
    cmd_left[i] = 8'hA5; cmd_right[i] = 8'h5A; cmd_op[i] = 8'hFF;
    lat = 0; nl = 0; nr = 0; no = 0; busy_bad = 1'b0; data_bad = 1'b0;
    while (!rsp_valid[i] && lat < 60) begin
      if (clk_l[i]) nl++;
      if (clk_r[i]) nr++;
      if (clk_o[i]) no++;
      if (cmd_ready[i]) busy_bad = 1'b1;
      if (num_l[i] !== l || num_r[i] !== r || op_c[i] !== o) data_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(2 + sw_of(i) + st_of(i)));
    check("pulses_left", 32'(nl), el ? 32'(sw_of(i)) : 32'd0);
    check("pulses_right", 32'(nr), er ? 32'(sw_of(i)) : 32'd0);
    check("pulses_op", 32'(no), eo ? 32'(sw_of(i)) : 32'd0);
    check("busy_ready_low", 32'(busy_bad), 32'd0);
    check("data_stable", 32'(data_bad), 32'd0);
    check("result", 32'(rsp_result[i]), 32'(ref_fn(l, r, o)));
    if (!ready_early) begin
      hold = rsp_result[i];
      stable = 1'b1;
      for (int k = 0; k < bp; k++) begin
        cmd_valid[i] = 1'b1;
        cmd_left[i] = 8'($urandom_range(0, 255));
        @(negedge clk);
        if (!rsp_valid[i] || rsp_result[i] !== hold || cmd_ready[i] || clk_l[i] || clk_r[i] || clk_o[i])
          stable = 1'b0;
      end
      cmd_valid[i] = 1'b0;
      check("resp_hold", 32'(stable), 32'd1);
      rsp_ready[i] = 1'b1;
    end
    @(negedge clk);
    rsp_ready[i] = 1'b0;
    check("rsp_done_valid", 32'(rsp_valid[i]), 32'd0);
    check("rsp_done_ready", 32'(cmd_ready[i]), 32'd1);
  endtask

  task automatic check_reset_state(input int i);
    check("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
    check("rst_rsp_result", 32'(rsp_result[i]), 32'd0);
    check("rst_data", {8'h0, num_l[i], num_r[i], op_c[i]}, 32'd0);
    check("rst_strobes", {29'h0, clk_l[i], clk_r[i], clk_o[i]}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int waitc;
    for (int i = 0; i < N; i++) begin
      cmd_valid[i] = 1'b0; cmd_left[i] = '0; cmd_right[i] = '0; cmd_op[i] = '0;
      rsp_ready[i] = 1'b0; mvalid[i] = 1'b0;
      last_l[i] = '0; last_r[i] = '0; last_o[i] = '0;
    end

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) check_reset_state(i);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check("ready_after_reset", 32'(cmd_ready[i]), 32'd1);
      check_reset_state(i);
    end

    // Basic op, then a right-only change (exercises unchanged-operand skipping when enabled).
    run_op(0, 8'd3, 8'd11, 8'h11, 0, 1'b1);
    run_op(0, 8'd3, 8'd20, 8'h11, 10, 1'b0);
    run_op(1, 8'd3, 8'd11, 8'h11, 2, 1'b0);
    run_op(1, 8'd3, 8'd11, 8'h11, 0, 1'b1);

    for (int n = 0; n < 12; n++) begin
      int i;
      i = (n % 3 == 2) ? 1 : 0;
      run_op(i, 8'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
             8'h10 | 8'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset during a strobe pulse on the long-strobe instance.
    @(negedge clk);
    cmd_valid[1] = 1'b1; cmd_left[1] = 8'd7; cmd_right[1] = 8'd9; cmd_op[1] = 8'h12;
    @(negedge clk);
    cmd_valid[1] = 1'b0;
    waitc = 0;
    while (!clk_l[1] && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check("strobe_seen", 32'(clk_l[1]), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state(1);
    check_reset_state(0);
    for (int i = 0; i < N; i++) mvalid[i] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_midreset", 32'(cmd_ready[1]), 32'd1);

    run_op(1, 8'd7, 8'd9, 8'h12, 1, 1'b0);
    run_op(0, 8'd3, 8'd11, 8'h11, 0, 1'b1);
    run_op(0, 8'd3, 8'd11, 8'h13, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
